// File: rtl/sobel_line_buffer.sv
// Line buffer for the Sobel window: keeps the last NR_OF_LINES-1 lines in a ring of
// read-first line memories and emits one masked vertical pixel column per accepted pixel.
module sobel_line_buffer #(
    parameter int WIDTH       = 8,
    parameter int LINE_LENGTH = 640,
    parameter int NR_OF_LINES = 3,
    parameter int COL_BITS    = $clog2(LINE_LENGTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic                         startOfLine,
    input  logic                         pixelValid,
    input  logic [WIDTH-1:0]             pixelIn,
    output logic [WIDTH*NR_OF_LINES-1:0] columnOut,
    output logic                         columnValid,
    output logic [COL_BITS-1:0]          columnX,
    output logic                         windowReady,
    output logic                         overflowError
);

    localparam int NM        = NR_OF_LINES - 1;
    localparam int CNT_BITS  = $clog2(LINE_LENGTH + 1);
    localparam int WP_BITS   = (NM > 1) ? $clog2(NM) : 1;
    localparam int FILL_BITS = $clog2(NR_OF_LINES);

    logic [CNT_BITS-1:0]  col_q, col_d, col_eff_s;
    logic [WP_BITS-1:0]   wp_q, wp_d, wp_eff_s;
    logic [FILL_BITS-1:0] fill_q, fill_d, fill_eff_s;
    logic                 ovf_q, ovf_d;
    logic                 line_end_s, accept_s;

    logic                 s1_valid_q;
    logic [WIDTH-1:0]     s1_pix_q;
    logic [COL_BITS-1:0]  s1_x_q;
    logic [WP_BITS-1:0]   s1_wp_q;
    logic [FILL_BITS-1:0] s1_fill_q;
    logic [WIDTH*NM-1:0]  rd_flat_s;

    logic [WIDTH*NR_OF_LINES-1:0] column_q, column_d;
    logic                         valid_q;
    logic [COL_BITS-1:0]          x_q;
    logic                         ready_q;

    // Control pulses act before a pixel in the same cycle, so derive post-control state first.
    always_comb begin
        line_end_s = startOfLine && (col_q != '0);
        col_eff_s  = col_q;
        wp_eff_s   = wp_q;
        fill_eff_s = fill_q;
        if (startOfFrame) begin
            col_eff_s  = '0;
            wp_eff_s   = '0;
            fill_eff_s = '0;
        end else if (line_end_s) begin
            col_eff_s  = '0;
            wp_eff_s   = (wp_q == WP_BITS'(NM - 1)) ? '0 : wp_q + WP_BITS'(1);
            fill_eff_s = (fill_q == FILL_BITS'(NM)) ? fill_q : fill_q + FILL_BITS'(1);
        end else begin
            col_eff_s  = col_q;
        end
        accept_s = pixelValid && (col_eff_s < CNT_BITS'(LINE_LENGTH));
        col_d    = accept_s ? col_eff_s + CNT_BITS'(1) : col_eff_s;
        wp_d     = wp_eff_s;
        fill_d   = fill_eff_s;
        if (startOfFrame) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (pixelValid & ~accept_s);
        end
    end

    // Line state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q  <= '0;
            wp_q   <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            wp_q   <= wp_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NM; g++) begin : g_line
            logic [WIDTH-1:0] mem_q [LINE_LENGTH];
            logic [WIDTH-1:0] rd_q;

            // Read-first port: the ring slot being overwritten yields the oldest line.
            always_ff @(posedge clock) begin
                if (accept_s) begin
                    rd_q <= mem_q[col_eff_s[COL_BITS-1:0]];
                    if (wp_eff_s == WP_BITS'(g)) begin
                        mem_q[col_eff_s[COL_BITS-1:0]] <= pixelIn;
                    end
                end
            end

            assign rd_flat_s[g*WIDTH +: WIDTH] = rd_q;
        end
    endgenerate

    // Capture pixel side-band alongside the memory read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_x_q     <= '0;
            s1_wp_q    <= '0;
            s1_fill_q  <= '0;
        end else begin
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_pix_q  <= pixelIn;
                s1_x_q    <= col_eff_s[COL_BITS-1:0];
                s1_wp_q   <= wp_eff_s;
                s1_fill_q <= fill_eff_s;
            end
        end
    end

    // Slice k reads the ring slot k lines behind the write pointer; unfilled rows read as zero.
    always_comb begin
        column_d = '0;
        column_d[WIDTH-1:0] = s1_pix_q;
        for (int k = 1; k < NR_OF_LINES; k++) begin
            if (k <= int'(s1_fill_q)) begin
                column_d[k*WIDTH +: WIDTH] = rd_flat_s[((int'(s1_wp_q) + NM - k) % NM)*WIDTH +: WIDTH];
            end else begin
                column_d[k*WIDTH +: WIDTH] = '0;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            column_q <= '0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            ready_q  <= 1'b0;
        end else begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                column_q <= column_d;
                x_q      <= s1_x_q;
                ready_q  <= (s1_fill_q == FILL_BITS'(NM));
            end
        end
    end

    assign columnOut     = column_q;
    assign columnValid   = valid_q;
    assign columnX       = x_q;
    assign windowReady   = ready_q;
    assign overflowError = ovf_q;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer (WIDTH=8, LINE_LENGTH=8, NR_OF_LINES=3).
module tb_sobel_line_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        startOfFrame, startOfLine, pixelValid;
    logic [7:0]  pixelIn;
    logic [23:0] columnOut;
    logic        columnValid;
    logic [2:0]  columnX;
    logic        windowReady;
    logic        overflowError;

    int total = 0;
    int bad   = 0;
    int nstrobe = 0;

    typedef struct packed {
        logic [23:0] col;
        logic [2:0]  x;
        logic        wr;
    } exp_t;
    exp_t sb[$];

    sobel_line_buffer #(.WIDTH(8), .LINE_LENGTH(8), .NR_OF_LINES(3)) dut (
        .clock(clock), .reset(reset), .startOfFrame(startOfFrame), .startOfLine(startOfLine),
        .pixelValid(pixelValid), .pixelIn(pixelIn), .columnOut(columnOut), .columnValid(columnValid),
        .columnX(columnX), .windowReady(windowReady), .overflowError(overflowError)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected column for row r (rows counted from the frame start) at column c; pixel = base + r*16 + c.
    task automatic push_exp(input int r, input int c, input int base);
        exp_t e;
        e.col = 24'h0;
        for (int k = 0; k < 3; k++) begin
            if (r - k >= 0) e.col[k*8 +: 8] = 8'((base + (r - k) * 16 + c) & 255);
        end
        e.x  = 3'(c);
        e.wr = (r >= 2);
        sb.push_back(e);
    endtask

    task automatic drive(input logic sof, input logic sol, input logic v, input logic [7:0] d);
        startOfFrame = sof; startOfLine = sol; pixelValid = v; pixelIn = d;
        @(posedge clock); #1;
        startOfFrame = 1'b0; startOfLine = 1'b0; pixelValid = 1'b0; pixelIn = 8'h00;
    endtask

    // Full line of pixels; first pixel may carry a control pulse.
    task automatic line(input int r, input int base, input logic sof, input logic sol);
        for (int c = 0; c < 8; c++) begin
            push_exp(r, c, base);
            drive((c == 0) ? sof : 1'b0, (c == 0) ? sol : 1'b0, 1'b1, 8'((base + r * 16 + c) & 255));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare every presented column against the scoreboard head.
    always @(negedge clock) begin
        if (columnValid) begin
            exp_t e;
            nstrobe++;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_column: got x=%0d col=%06h expected no strobe", columnX, columnOut);
            end else begin
                e = sb.pop_front();
                chk("columnOut", 32'(columnOut), 32'(e.col));
                chk("columnX", 32'(columnX), 32'(e.x));
                chk("windowReady", 32'(windowReady), 32'(e.wr));
            end
        end
    end

    int s0;

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; startOfLine = 1'b0; pixelValid = 1'b0; pixelIn = 8'h00;
        #23;
        chk("rst_columnOut", 32'(columnOut), 32'h0);
        chk("rst_columnValid", 32'(columnValid), 32'h0);
        chk("rst_columnX", 32'(columnX), 32'h0);
        chk("rst_windowReady", 32'(windowReady), 32'h0);
        chk("rst_overflow", 32'(overflowError), 32'h0);
        @(negedge clock); reset = 1'b0;
        idle(2);

        // Frame A: sof with first pixel, empty line pulses, sol with first pixel, ring wrap over 5 lines.
        line(0, 0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        line(1, 0, 1'b0, 1'b0);
        line(2, 0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        line(3, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        line(4, 0, 1'b0, 1'b0);
        idle(3);
        chk("no_overflow_yet", 32'(overflowError), 32'h0);

        // Overflow frame: 9 pixels in one 8-pixel line.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        s0 = nstrobe;
        line(0, 'h50, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hEE);
        chk("overflow_set", 32'(overflowError), 32'h1);
        idle(3);
        chk("overflow_strobes", 32'(nstrobe - s0), 32'd8);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        line(1, 'h50, 1'b0, 1'b0);
        idle(3);
        chk("overflow_sticky", 32'(overflowError), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        chk("overflow_cleared", 32'(overflowError), 32'h0);

        // Reset mid-stream during row 2 col 4; the in-flight pixel must be dropped.
        line(0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        line(1, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            push_exp(2, c, 0);
            drive(1'b0, 1'b0, 1'b1, 8'(32 + c));
        end
        drive(1'b0, 1'b0, 1'b1, 8'h24);
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_columnOut", 32'(columnOut), 32'h0);
        chk("mid_rst_columnValid", 32'(columnValid), 32'h0);
        chk("mid_rst_columnX", 32'(columnX), 32'h0);
        chk("mid_rst_windowReady", 32'(windowReady), 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        line(0, 'h80, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        line(1, 'h80, 1'b0, 1'b0);
        idle(4);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
